// File: rtl/bp_me_hw_looper_multi.sv
// Multi-channel hardware looper: each channel streams (global, local) index pairs
// from a two-level nested loop, programmed through a one-outstanding config port.
module bp_me_hw_looper_multi #(
  parameter int num_channels_p = 4,
  parameter int index_width_p  = 64,
  parameter int data_width_p   = 64,
  parameter int offset_width_p = 20
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    cfg_v_i,
  input  logic                                    cfg_w_i,
  input  logic [offset_width_p-1:0]               cfg_addr_i,
  input  logic [data_width_p-1:0]                 cfg_data_i,
  output logic                                    cfg_ready_o,
  output logic                                    cfg_v_o,
  output logic [data_width_p-1:0]                 cfg_data_o,
  input  logic                                    cfg_yumi_i,
  output logic [num_channels_p-1:0]               idx_v_o,
  output logic [num_channels_p*index_width_p-1:0] idx_global_o,
  output logic [num_channels_p*index_width_p-1:0] idx_local_o,
  input  logic [num_channels_p-1:0]               idx_yumi_i,
  output logic [num_channels_p-1:0]               done_o
);
  localparam int chan_width_lp = offset_width_p - 6;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  logic                     ready_r, resp_v_r, accept, aligned;
  logic [data_width_p-1:0]  resp_data_r, rd_data;
  logic [chan_width_lp-1:0] chan_sel;
  logic [2:0]               reg_sel;
  logic [data_width_p-1:0]  rd_chan [num_channels_p];

  assign accept   = cfg_v_i & ready_r;
  assign chan_sel = cfg_addr_i[offset_width_p-1:6];
  assign reg_sel  = cfg_addr_i[5:3];
  assign aligned  = (cfg_addr_i[2:0] == 3'b000);

  // Only a matching in-range channel drives its slot, so OR-ing yields 0 for unmapped reads.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < num_channels_p; c++) rd_data = rd_data | rd_chan[c];
    if (cfg_w_i) rd_data = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_r     <= 1'b0;
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
    end else if (accept) begin
      ready_r     <= 1'b0;
      resp_v_r    <= 1'b1;
      resp_data_r <= rd_data;
    end else if (resp_v_r && cfg_yumi_i) begin
      ready_r     <= 1'b1;
      resp_v_r    <= 1'b0;
    end else if (!resp_v_r) begin
      ready_r     <= 1'b1;
    end
  end

  assign cfg_ready_o = ready_r;
  assign cfg_v_o     = resp_v_r;
  assign cfg_data_o  = resp_data_r;

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
    localparam logic [chan_width_lp-1:0] id_lp = chan_width_lp'(c);

    state_e                   state_r, state_n;
    logic [index_width_p-1:0] gstart_r, gend_r, lstart_r, lend_r, lstride_r;
    logic [index_width_p-1:0] g_r, l_r, stride, wdata, g_out, l_out;
    logic [index_width_p:0]   nl;
    logic                     hit, ctrl_wr, reg_wr, start, abort, clear;
    logic                     yumi, empty, l_wrap, last, v, busy, done;
    logic [data_width_p-1:0]  rd;

    assign hit     = aligned & (chan_sel == id_lp);
    assign ctrl_wr = accept & cfg_w_i & hit & (reg_sel == 3'd0);
    assign reg_wr  = accept & cfg_w_i & hit & (state_r != ST_RUN);
    assign start   = ctrl_wr & cfg_data_i[0];
    assign abort   = ctrl_wr & cfg_data_i[1];
    assign clear   = ctrl_wr & cfg_data_i[2];
    assign wdata   = index_width_p'(cfg_data_i);

    // Next local index is formed one bit wider so a stride past the top never wraps.
    assign stride = (lstride_r == '0) ? index_width_p'(1) : lstride_r;
    assign nl     = {1'b0, l_r} + {1'b0, stride};
    assign l_wrap = nl > {1'b0, lend_r};
    assign last   = l_wrap & (g_r == gend_r);
    assign empty  = (gstart_r > gend_r) | (lstart_r > lend_r);
    assign yumi   = idx_yumi_i[c] & (state_r == ST_RUN);

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        gstart_r  <= '0;
        gend_r    <= '0;
        lstart_r  <= '0;
        lend_r    <= '0;
        lstride_r <= '0;
      end else if (reg_wr) begin
        case (reg_sel)
          3'd1:    gstart_r  <= wdata;
          3'd2:    gend_r    <= wdata;
          3'd3:    lstart_r  <= wdata;
          3'd4:    lend_r    <= wdata;
          3'd5:    lstride_r <= wdata;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= ST_IDLE;
      else         state_r <= state_n;
    end

    always_comb begin
      state_n = state_r;
      if (abort) begin
        state_n = ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: if (start) state_n = empty ? ST_DONE : ST_RUN;
          ST_RUN:  if (yumi && last) state_n = ST_DONE;
          ST_DONE: begin
            if (start)      state_n = empty ? ST_DONE : ST_RUN;
            else if (clear) state_n = ST_IDLE;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        g_r <= '0;
        l_r <= '0;
      end else if (start && !abort && state_r != ST_RUN) begin
        g_r <= gstart_r;
        l_r <= lstart_r;
      end else if (yumi) begin
        if (!l_wrap) begin
          l_r <= nl[index_width_p-1:0];
        end else if (!last) begin
          l_r <= lstart_r;
          g_r <= g_r + index_width_p'(1);
        end
      end
    end

    always_comb begin
      v     = (state_r == ST_RUN);
      busy  = (state_r == ST_RUN);
      done  = (state_r == ST_DONE);
      g_out = v ? g_r : '0;
      l_out = v ? l_r : '0;
    end

    always_comb begin
      rd = '0;
      if (hit) begin
        case (reg_sel)
          3'd1:    rd = data_width_p'(gstart_r);
          3'd2:    rd = data_width_p'(gend_r);
          3'd3:    rd = data_width_p'(lstart_r);
          3'd4:    rd = data_width_p'(lend_r);
          3'd5:    rd = data_width_p'(lstride_r);
          3'd6:    rd = data_width_p'({done, busy});
          default: rd = '0;
        endcase
      end
    end

    assign rd_chan[c]                                    = rd;
    assign idx_v_o[c]                                    = v;
    assign done_o[c]                                     = done;
    assign idx_global_o[c*index_width_p +: index_width_p] = g_out;
    assign idx_local_o[c*index_width_p +: index_width_p]  = l_out;
  end

endmodule

// File: doc/bp_me_hw_looper_multi.md
Name: bp_me_hw_looper_multi

Overview:
- Memory-mapped multi-channel hardware looper device; successor to the single-channel looper at device base 0x0050_0000.
- Each channel runs an independent two-level nested loop: an outer "global" index and an inner "local" index, with a programmable local stride.
- Each channel streams (global, local) index pairs to a consumer over a valid/yumi handshake.
- Sits behind the config/IO network; software programs it through loads and stores.

Parameters:
num_channels_p, 4, number of independent looper channels (1..16)
index_width_p, 64, width of all index, bound and stride registers
data_width_p, 64, width of config data bus
offset_width_p, 20, device-local address offset width (low bits of 0x005X_XXXX)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high, clears all state
cfg_v_i  in  1  config request valid
cfg_w_i  in  1  1=write, 0=read
cfg_addr_i  in  offset_width_p  device-local byte offset
cfg_data_i  in  data_width_p  write data
cfg_ready_o  out  1  request accepted when cfg_v_i & cfg_ready_o
cfg_v_o  out  1  response valid
cfg_data_o  out  data_width_p  read data; 0 for writes
cfg_yumi_i  in  1  response consumed
idx_v_o  out  num_channels_p  per-channel index valid
idx_global_o  out  num_channels_p*index_width_p  per-channel outer index
idx_local_o  out  num_channels_p*index_width_p  per-channel inner index
idx_yumi_i  in  num_channels_p  per-channel index consumed (only when idx_v_o set)
done_o  out  num_channels_p  per-channel sticky completion flag

Behaviour:
- Reset: all outputs 0; cfg_ready_o becomes 1 on the first cycle after reset deasserts. All registers 0; all channels IDLE.
- Register map: channel c window = c*0x40.
  - 0x00 CTRL (write-only; reads 0): bit0 start, bit1 abort, bit2 clear_done.
  - 0x08 GSTART, 0x10 GEND, 0x18 LSTART, 0x20 LEND, 0x28 LSTRIDE (read/write).
  - 0x30 STATUS (read-only): bit0 busy, bit1 done.
- Unmapped offset or c >= num_channels_p: read returns 0, write is dropped; the response is still returned.
- Config handshake: one outstanding request.
  - Request accepted -> cfg_v_o asserted next cycle; cfg_ready_o=0 while the response is pending.
  - cfg_v_o held until cfg_yumi_i, then cfg_ready_o=1 the following cycle.
  - Write side effects take place on the accept edge.
- Writes to GSTART..LSTRIDE while the channel is busy are acknowledged and ignored.
- Channel FSM: IDLE -> RUN -> DONE.
  - IDLE + start: if GSTART>GEND or LSTART>LEND (unsigned), go to DONE with no index issued. Otherwise g=GSTART, l=LSTART, go to RUN.
  - RUN: idx_v_o=1 with idx_global_o=g, idx_local_o=l; outputs held stable until yumi.
  - On yumi, nl = l+LSTRIDE computed at index_width_p+1 bits (no wrap):
    - nl <= LEND: l=nl.
    - else if g==GEND: go to DONE (idx_v_o=0 next cycle).
    - else l=LSTART, g=g+1.
  - LSTRIDE==0 is treated as 1.
  - DONE: done flag set, busy=0. Start re-launches as from IDLE and clears done. clear_done -> IDLE.
- Abort in any state -> IDLE, done cleared, idx_v_o=0 next cycle. Abort with start in the same write: abort wins. Start while RUN is ignored.
- Yumi and abort on the same cycle: the yumi'd index counts as consumed; the channel still goes to IDLE.
- Latency: start write accepted at cycle N -> idx_v_o at N+1. Back-to-back yumi gives one index per cycle per channel.
- Channels are fully independent; simultaneous yumis on different channels do not interact.
- Reset mid-loop: immediate return to IDLE, all registers cleared.

Test Plan:
- Ch0: GSTART=0, GEND=1, LSTART=2, LEND=4, LSTRIDE=1, start; yumi every cycle -> pairs (0,2)(0,3)(0,4)(1,2)(1,3)(1,4); done_o[0]=1 on the cycle after the last yumi; STATUS read = 0x2.
- Ch1: LSTART=0, LEND=10, LSTRIDE=4, GSTART=GEND=7 -> (7,0)(7,4)(7,8) then done. Repeat with LEND=2^64-1, LSTART=2^64-2, LSTRIDE=3 -> (g,2^64-2) only; no wrap.
- Empty range GSTART=5, GEND=4: start -> done_o set next cycle, idx_v_o never asserted. Then clear_done -> STATUS=0.
- Ch2 running, hold yumi low for 5 cycles -> outputs stable. Write CTRL=0x3 -> IDLE, idx_v_o=0, done_o=0. A GEND write while busy is ignored (readback shows the old value).
- All 4 channels started together with random yumi patterns -> each sequence matches the reference model. Address 0x100 (c=4) read returns 0, and the handshake completes with cfg_yumi_i delayed 3 cycles.
- Assert reset_i asynchronously mid-RUN -> idx_v_o, done_o and cfg_v_o drop immediately; readback of all registers = 0.
